uart_pic_loader: RTL
====================

Name: uart_pic_loader

Overview:
Parametrised UART-to-frame-buffer loader between uart_rx (po_data/po_flag) and the picture RAM write port of the VGA picture path. Replaces the fixed 8-bit, fixed-size picture receive with a framed protocol (sync byte + mode byte) and configurable picture size and pixel width. Adds a solid-fill mode, an inter-byte timeout and frame status pulses. Single clock domain; the picture RAM read side is outside this block.

Parameters:
PIC_W, 100, picture width in pixels (≥1)
PIC_H, 100, picture height in lines (≥1)
PIX_BYTES, 1, bytes per pixel, 1 or 2; two-byte pixels are big-endian (first byte = MSB)
ADDR_W, 14, write address width; PIC_W*PIC_H ≤ 2^ADDR_W
SYNC_BYTE, 8'hA5, frame start marker
TIMEOUT_CYC, 50_000_000, idle sys_clk cycles tolerated between bytes inside a frame

Ports:
sys_clk  in  1  system clock
sys_rst  in  1  reset: synchronous, active-high
pi_data  in  8  received byte, valid only while pi_flag=1
pi_flag  in  1  one-cycle byte strobe
wr_en  out  1  RAM write strobe
wr_addr  out  ADDR_W  row-major address y*PIC_W+x
wr_data  out  8*PIX_BYTES  pixel value
busy  out  1  high in every state except IDLE
frame_done  out  1  one-cycle pulse: frame fully written (and checksum passed if enabled)
frame_err  out  1  one-cycle pulse: timeout or checksum mismatch

Behaviour:
- Reset: state=IDLE; wr_en, busy, frame_done, frame_err = 0; wr_addr, wr_data = 0; all counters 0. Reset mid-frame aborts immediately without an error pulse. Already-written RAM content is not rolled back.
- IDLE: pi_flag with pi_data==SYNC_BYTE -> MODE. All other bytes are discarded.
- MODE: next byte latched as mode. Bit0=1 -> FILL_VAL; bit0=0 -> RAW. Bits 7:1 are ignored.
- RAW: collect PIX_BYTES bytes per pixel. On the strobe of the pixel's last byte, register wr_data/wr_addr and assert wr_en for exactly one cycle on the next cycle (latency 1).
  - Address advances by 1 per written pixel, starting at 0.
  - Internal x/y counters wrap x at PIC_W-1.
  - After pixel index PIC_W*PIC_H-1 is written -> END.
- FILL_VAL: collect PIX_BYTES value bytes -> FILL.
- FILL: wr_en=1 every cycle with wr_data=value and wr_addr stepping 0..PIC_W*PIC_H-1 (one pixel per clock). After the last address -> END. pi_flag strobes during FILL are dropped and do not affect the frame.
- END (CHKSUM_EN undefined): frame_done pulse for one cycle -> IDLE.
- Timeout: in MODE, RAW, FILL_VAL (and CHK if enabled), a counter reloads on every pi_flag. Reaching TIMEOUT_CYC with no byte -> frame_err pulse, return to IDLE; partial pixel bytes are discarded. No timeout applies in FILL or IDLE.
- A SYNC_BYTE value inside RAW/FILL_VAL is treated as data; there is no resync mid-frame.
- A pi_flag arriving in the same cycle as END or a timeout is dropped.
- busy is 1 from the cycle after the sync byte until the cycle the done/err pulse asserts, inclusive of that cycle.

Optional Feature:
CHKSUM_EN:
- Defined: END becomes CHK. The block waits for one checksum byte equal to the 8-bit modulo-256 sum of every byte following the mode byte (pixel bytes, or the fill value bytes).
  - Match -> frame_done pulse.
  - Mismatch -> frame_err pulse, no frame_done.
  - Either outcome returns to IDLE one cycle later.
  - Timeout applies in CHK.
  - The running sum clears in MODE.
- Undefined: no checksum byte, no sum logic; frame_done fires directly from END.

Test Plan:
- PIC_W=4, PIC_H=2, PIX_BYTES=1: send A5,00,10..17 -> 8 wr_en pulses at addr 0..7 with data 10..17, each one cycle after the byte strobe; one frame_done; busy low afterwards.
- PIX_BYTES=2, same size: A5,00 then bytes 12,34,… -> first write data 16'h1234 at addr 0; exactly 8 writes for 16 bytes.
- Fill: A5,01,3C -> 8 consecutive-cycle writes of 8'h3C at addr 0..7, then frame_done. Bytes injected during the fill produce no extra writes.
- Leading junk 00,FF then A5,00,… -> junk ignored; frame writes start at addr 0.
- TIMEOUT_CYC=20: A5,00,10,11 then silence -> frame_err one cycle after 20 idle cycles; no frame_done; a following A5 restarts at addr 0.
- CHKSUM_EN, 4x2, A5,00,01×8 then 08 -> frame_done. Repeating with a final byte of 09 -> frame_err only.

Source files
------------

// File: rtl/uart_pic_loader.sv
// uart_pic_loader: framed UART byte stream (sync, mode, payload) to picture RAM.
// Optional trailing checksum byte is enabled by defining CHKSUM_EN.

module uart_pic_loader #(
  parameter int         PIC_W       = 100,
  parameter int         PIC_H       = 100,
  parameter int         PIX_BYTES   = 1,
  parameter int         ADDR_W      = 14,
  parameter logic [7:0] SYNC_BYTE   = 8'hA5,
  parameter int         TIMEOUT_CYC = 50_000_000
) (
  input  logic                   sys_clk,
  input  logic                   sys_rst,
  input  logic [7:0]             pi_data,
  input  logic                   pi_flag,
  output logic                   wr_en,
  output logic [ADDR_W-1:0]      wr_addr,
  output logic [8*PIX_BYTES-1:0] wr_data,
  output logic                   busy,
  output logic                   frame_done,
  output logic                   frame_err
);

  localparam int DW = 8 * PIX_BYTES;
  localparam int XW = (PIC_W > 1) ? $clog2(PIC_W) : 1;
  localparam int YW = (PIC_H > 1) ? $clog2(PIC_H) : 1;
  localparam int TW = $clog2(TIMEOUT_CYC + 1);

  localparam logic [XW-1:0]     X_LAST = XW'(PIC_W - 1);
  localparam logic [YW-1:0]     Y_LAST = YW'(PIC_H - 1);
  localparam logic [ADDR_W-1:0] A_LAST = ADDR_W'(PIC_W * PIC_H - 1);
  localparam logic [TW-1:0]     T_MAX  = TW'(TIMEOUT_CYC);
  localparam logic [1:0]        B_LAST = 2'(PIX_BYTES - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_MODE, S_RAW, S_FVAL,
    S_FILL, S_END,  S_ERR, S_CHK
  } state_t;

`ifdef CHKSUM_EN
  localparam state_t S_TAIL = S_CHK;
`else
  localparam state_t S_TAIL = S_END;
`endif

  state_t            state_q, state_d;
  logic [TW-1:0]     cnt_q, cnt_d;
  logic [ADDR_W-1:0] idx_q, idx_d;
  logic [XW-1:0]     x_q, x_d;
  logic [YW-1:0]     y_q, y_d;
  logic [1:0]        bcnt_q, bcnt_d;
  logic [DW-1:0]     shf_q, shf_d;
  logic              wr_en_q, wr_en_d;
  logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
  logic [DW-1:0]     wr_data_q, wr_data_d;
`ifdef CHKSUM_EN
  logic [7:0]        sum_q, sum_d;
`endif

  logic          timed;
  logic          tmo;
  logic          last_b;
  logic          last_p;
  logic [DW-1:0] asm_px;

  // State and datapath registers
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      idx_q     <= '0;
      x_q       <= '0;
      y_q       <= '0;
      bcnt_q    <= '0;
      shf_q     <= '0;
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
`ifdef CHKSUM_EN
      sum_q     <= '0;
`endif
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      idx_q     <= idx_d;
      x_q       <= x_d;
      y_q       <= y_d;
      bcnt_q    <= bcnt_d;
      shf_q     <= shf_d;
      wr_en_q   <= wr_en_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
`ifdef CHKSUM_EN
      sum_q     <= sum_d;
`endif
    end
  end

  // Next-state, inter-byte timeout and write generation
  always_comb begin
    state_d   = state_q;
    cnt_d     = '0;
    idx_d     = idx_q;
    x_d       = x_q;
    y_d       = y_q;
    bcnt_d    = bcnt_q;
    shf_d     = shf_q;
    wr_en_d   = 1'b0;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
`ifdef CHKSUM_EN
    sum_d     = sum_q;
`endif

    timed  = (state_q == S_MODE) || (state_q == S_RAW) ||
             (state_q == S_FVAL) || (state_q == S_CHK);
    tmo    = timed && (cnt_q == T_MAX);
    last_b = (bcnt_q == B_LAST);
    last_p = (x_q == X_LAST) && (y_q == Y_LAST);
    asm_px = DW'({shf_q, pi_data});

    if (timed && !pi_flag && !tmo)
      cnt_d = cnt_q + TW'(1);

    // A timeout wins over a byte in the same cycle; the byte is lost.
    if (tmo) begin
      state_d = S_ERR;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          idx_d  = '0;
          x_d    = '0;
          y_d    = '0;
          bcnt_d = '0;
          if (pi_flag && (pi_data == SYNC_BYTE))
            state_d = S_MODE;
        end
        S_MODE: begin
`ifdef CHKSUM_EN
          sum_d = '0;
`endif
          if (pi_flag)
            state_d = pi_data[0] ? S_FVAL : S_RAW;
        end
        S_RAW: begin
          if (pi_flag) begin
`ifdef CHKSUM_EN
            sum_d = sum_q + pi_data;
`endif
            shf_d = asm_px;
            if (last_b) begin
              bcnt_d    = '0;
              wr_en_d   = 1'b1;
              wr_addr_d = idx_q;
              wr_data_d = asm_px;
              idx_d     = idx_q + ADDR_W'(1);
              if (x_q == X_LAST) begin
                x_d = '0;
                y_d = y_q + YW'(1);
              end else begin
                x_d = x_q + XW'(1);
              end
              if (last_p)
                state_d = S_TAIL;
            end else begin
              bcnt_d = bcnt_q + 2'd1;
            end
          end
        end
        S_FVAL: begin
          if (pi_flag) begin
`ifdef CHKSUM_EN
            sum_d = sum_q + pi_data;
`endif
            shf_d = asm_px;
            if (last_b) begin
              bcnt_d  = '0;
              state_d = S_FILL;
            end else begin
              bcnt_d = bcnt_q + 2'd1;
            end
          end
        end
        S_FILL: begin
          wr_en_d   = 1'b1;
          wr_addr_d = idx_q;
          wr_data_d = shf_q;
          idx_d     = idx_q + ADDR_W'(1);
          if (idx_q == A_LAST)
            state_d = S_TAIL;
        end
`ifdef CHKSUM_EN
        S_CHK: begin
          if (pi_flag)
            state_d = (pi_data == sum_q) ? S_END : S_ERR;
        end
`endif
        S_END:   state_d = S_IDLE;
        S_ERR:   state_d = S_IDLE;
        default: state_d = S_IDLE;
      endcase
    end
  end

  assign wr_en      = wr_en_q;
  assign wr_addr    = wr_addr_q;
  assign wr_data    = wr_data_q;
  assign busy       = (state_q != S_IDLE);
  assign frame_done = (state_q == S_END);
  assign frame_err  = (state_q == S_ERR);

endmodule
